svi_scalar_monitor: RTL and testbench
=====================================

// Module: svi_scalar_monitor
// PURPOSE
//  Consumer end of interface I: samples scalars z, y, x through the input-only
//  modport C and reports registered edges, per-signal rise counts and a
//  debounced "stable" flag.
//  Sits beside the producer that drives z/y/x via modport P. It checks that
//  producer-side always_ff writes are visible, in order, to a reader.
// PARAMETERS
//  CNT_W  8  width of each saturating rise counter (>=2)
//  HOLD   4  consecutive unchanged samples required for o_stable (>=2)
// PORTS
//  i_clk     input   1      clock; all state updates on posedge
//  i_srst    input   1      synchronous reset, active-high
//  p         modport I.C    consumer view; reads p.z, p.y, p.x (all inputs)
//  i_clr     input   1      synchronous clear of rise counters
//  o_zyx     output  3      registered sample {z,y,x}
//  o_rise    output  3      one-cycle rise pulse per bit {z,y,x}
//  o_fall    output  3      one-cycle fall pulse per bit {z,y,x}
//  o_cnt_z   output  CNT_W  rise count of z
//  o_cnt_y   output  CNT_W  rise count of y
//  o_cnt_x   output  CNT_W  rise count of x
//  o_stable  output  1      high while sample unchanged >= HOLD samples
// BEHAVIOUR
//  Reset (i_srst=1 at posedge): every output is 0, the FSM is in TRACK, the run
//   counter is 0 and the prime flag v is 0. Reset mid-operation aborts all
//   pulses and counts on that same edge.
//  Stage 1: q1 <= {p.z,p.y,p.x} and v <= 1. o_zyx = q1, so latency is 1 cycle.
//  Stage 2: q2 <= q1.
//   - o_rise <= v ? (q1 & ~q2) : 0
//   - o_fall <= v ? (~q1 & q2) : 0
//   - Pulse latency is 2 cycles from the input change; each pulse lasts 1 cycle.
//   - Priming: v=0 on the first sample after reset, so no edge is reported for
//     any value present at reset release.
//  Counters: o_cnt_k increments on the edge that registers o_rise[k]=1.
//   - Each counter saturates at 2^CNT_W-1 and never wraps.
//   - i_clr=1 forces all counters to 0. Clear wins over a simultaneous rise, so
//     the count is 0, not 1.
//   - Pulses are unaffected by i_clr.
//  Stability FSM, states TRACK and STABLE, with run counter r (width clog2(HOLD+1)):
//   - Any edge: q1 != q2 with v=1 sets r=0, state=TRACK, and registers
//     o_stable=0.
//   - No edge: r increments, saturating at HOLD.
//   - TRACK->STABLE when r reaches HOLD. o_stable registers 1 on that edge.
//   - STABLE->TRACK on the first edge. o_stable drops with the same registered
//     edge that raises o_rise/o_fall.
//   - While v=0, r stays 0.
//  Simultaneous edges on several bits: all pulse bits and counters update in the
//   same cycle, with independent saturation per counter.
//  No combinational path from p to any output.
// TESTING
//  Reset with p={1,1,1} held, release -> o_zyx=3'b111 next cycle; o_rise stays 0.
//   o_cnt_* stay 0, and o_stable=1 exactly HOLD+2 cycles after release.
//  z toggles 0->1->0 on cycles 10 and 11 -> o_rise=3'b100 at cycle 12.
//   o_fall=3'b100 at cycle 13; o_cnt_z=1; o_stable=0 from cycle 12.
//  With CNT_W=2, x rises 5 times -> o_cnt_x sequence 1,2,3,3,3 (no wrap).
//  y rises while i_clr=1 on the registering edge -> o_rise[1]=1, o_cnt_y=0.
//   Next y rise -> o_cnt_y=1.
//  i_srst asserted one cycle after a z rise reaches q1 -> o_rise stays 0.
//   o_cnt_z=0, and all outputs are 0 on the following cycle.
//  z,y,x all rise on the same cycle -> o_rise=3'b111 for one cycle.
//   All three counters increment by 1 together.

Source files
------------

// File: rtl/svi_scalar_monitor_if.sv
// Scalar bundle shared by the producer (P) and the monitoring consumer (C).
interface svi_scalar_monitor_if;
    logic z;
    logic y;
    logic x;

    modport P (output z, output y, output x);
    modport C (input z, input y, input x);
endinterface

// File: rtl/svi_scalar_monitor.sv
// Consumer-side monitor for the z/y/x bundle: registered sample, edge pulses,
// saturating rise counters and a debounced stability flag.
//
// state     | meaning
// ST_TRACK  | sample changed recently, waiting for HOLD quiet samples
// ST_STABLE | sample unchanged for at least HOLD samples, o_stable high
module svi_scalar_monitor #(
    parameter int CNT_W = 8,
    parameter int HOLD  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    svi_scalar_monitor_if.C      p,
    input  logic                 i_clr,
    output logic [2:0]           o_zyx,
    output logic [2:0]           o_rise,
    output logic [2:0]           o_fall,
    output logic [CNT_W-1:0]     o_cnt_z,
    output logic [CNT_W-1:0]     o_cnt_y,
    output logic [CNT_W-1:0]     o_cnt_x,
    output logic                 o_stable
);

    localparam int R_W = $clog2(HOLD + 1);
    localparam logic [R_W-1:0]   R_HOLD  = R_W'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_TRACK  = 1'b0,
        ST_STABLE = 1'b1
    } state_t;

    logic [2:0]       sample;
    logic [2:0]       q1_q;
    logic [2:0]       q2_q;
    logic             v_q;
    logic [2:0]       rise_d;
    logic [2:0]       fall_d;
    logic             edge_seen;
    state_t           state_q;
    state_t           state_d;
    logic [R_W-1:0]   r_q;
    logic [R_W-1:0]   r_d;
    logic [CNT_W-1:0] cnt_q [3];

    assign sample    = {p.z, p.y, p.x};
    assign rise_d    = v_q ? (q1_q & ~q2_q) : 3'b000;
    assign fall_d    = v_q ? (~q1_q & q2_q) : 3'b000;
    assign edge_seen = v_q && (q1_q != q2_q);

    // Stage 2 primes with the first sample so a level present at reset
    // release never looks like an edge.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            q1_q   <= 3'b000;
            q2_q   <= 3'b000;
            v_q    <= 1'b0;
            o_rise <= 3'b000;
            o_fall <= 3'b000;
        end else begin
            q1_q   <= sample;
            q2_q   <= v_q ? q1_q : sample;
            v_q    <= 1'b1;
            o_rise <= rise_d;
            o_fall <= fall_d;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_cnt
        always_ff @(posedge i_clk) begin
            if (i_srst || i_clr) begin
                cnt_q[k] <= '0;
            end else if (rise_d[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= ST_TRACK;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        if (!v_q) begin
            r_d = '0;
        end else if (edge_seen) begin
            r_d     = '0;
            state_d = ST_TRACK;
        end else begin
            if (r_q != R_HOLD) begin
                r_d = r_q + R_W'(1);
            end
            if ((state_q == ST_TRACK) && (r_q == R_HOLD)) begin
                state_d = ST_STABLE;
            end
        end
    end

    assign o_zyx    = q1_q;
    assign o_cnt_z  = cnt_q[2];
    assign o_cnt_y  = cnt_q[1];
    assign o_cnt_x  = cnt_q[0];
    assign o_stable = (state_q == ST_STABLE);

endmodule

// File: tb/tb_svi_scalar_monitor.sv
// Directed checks of svi_scalar_monitor; a second instance with 2-bit counters
// exercises saturation on the same stimulus.
module tb_svi_scalar_monitor;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       srst;
    logic       clr;
    logic [2:0] zyx, rise, fall;
    logic [7:0] cnt_z, cnt_y, cnt_x;
    logic       stable;
    logic [2:0] zyx2, rise2, fall2;
    logic [1:0] cnt2_z, cnt2_y, cnt2_x;
    logic       stable2;

    int n_vec = 0;
    int n_err = 0;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    svi_scalar_monitor_if intf ();

    svi_scalar_monitor #(.CNT_W(8), .HOLD(HOLD)) dut (
        .i_clk(clk), .i_srst(srst), .p(intf.C), .i_clr(clr),
        .o_zyx(zyx), .o_rise(rise), .o_fall(fall),
        .o_cnt_z(cnt_z), .o_cnt_y(cnt_y), .o_cnt_x(cnt_x), .o_stable(stable)
    );

    svi_scalar_monitor #(.CNT_W(2), .HOLD(HOLD)) dut2 (
        .i_clk(clk), .i_srst(srst), .p(intf.C), .i_clr(clr),
        .o_zyx(zyx2), .o_rise(rise2), .o_fall(fall2),
        .o_cnt_z(cnt2_z), .o_cnt_y(cnt2_y), .o_cnt_x(cnt2_x), .o_stable(stable2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        srst = 1'b1;
        clr  = 1'b0;
        intf.z = 1'b1; intf.y = 1'b1; intf.x = 1'b1;
        step(); step();
        check("rst_zyx",    32'(zyx), 32'h0);
        check("rst_rise",   32'(rise), 32'h0);
        check("rst_fall",   32'(fall), 32'h0);
        check("rst_cnt",    32'({cnt_z, cnt_y, cnt_x}), 32'h0);
        check("rst_stable", 32'(stable), 32'h0);

        srst = 1'b0;
        step();
        check("prime_zyx",  32'(zyx), 32'h7);
        check("prime_rise", 32'(rise), 32'h0);
        for (int i = 2; i <= HOLD + 1; i++) begin
            step();
            check("prime_rise_hold", 32'(rise | fall), 32'h0);
            check("pre_stable",      32'(stable), 32'h0);
        end
        step();
        check("stable_hold_plus_2", 32'(stable), 32'h1);
        check("prime_cnt",          32'({cnt_z, cnt_y, cnt_x}), 32'h0);

        intf.z = 1'b0; intf.y = 1'b0; intf.x = 1'b0;
        step();
        check("fall_pre_stable", 32'(stable), 32'h1);
        step();
        check("fall_all",        32'(fall), 32'h7);
        check("fall_all_rise",   32'(rise), 32'h0);
        check("fall_all_stable", 32'(stable), 32'h0);
        repeat (HOLD + 2) step();
        check("restable", 32'(stable), 32'h1);

        intf.z = 1'b1;
        step();
        check("zpulse_zyx",  32'(zyx), 32'h4);
        check("zpulse_rise_early", 32'(rise), 32'h0);
        intf.z = 1'b0;
        step();
        check("zpulse_rise",   32'(rise), 32'h4);
        check("zpulse_stable", 32'(stable), 32'h0);
        check("zpulse_cnt_z",  32'(cnt_z), 32'h1);
        step();
        check("zpulse_fall",      32'(fall), 32'h4);
        check("zpulse_rise_gone", 32'(rise), 32'h0);

        for (int i = 0; i < 5; i++) begin
            intf.x = 1'b1;
            step(); step();
            check("x_cnt8", 32'(cnt_x), 32'(i + 1));
            check("x_cnt2", 32'(cnt2_x), 32'(exp_sat[i]));
            intf.x = 1'b0;
            step(); step();
        end

        intf.y = 1'b1;
        step();
        clr = 1'b1;
        step();
        check("clr_rise",  32'(rise), 32'h2);
        check("clr_cnt_y", 32'(cnt_y), 32'h0);
        check("clr_cnt_x", 32'(cnt_x), 32'h0);
        check("clr_cnt_z", 32'(cnt_z), 32'h0);
        clr = 1'b0;
        intf.y = 1'b0;
        step(); step();
        intf.y = 1'b1;
        step(); step();
        check("clr_next_cnt_y", 32'(cnt_y), 32'h1);
        intf.y = 1'b0;
        step(); step();

        intf.z = 1'b1;
        step();
        check("abort_zyx_pre", 32'(zyx), 32'h4);
        srst = 1'b1;
        step();
        check("abort_rise",   32'(rise), 32'h0);
        check("abort_cnt_z",  32'(cnt_z), 32'h0);
        check("abort_all",    32'({zyx, fall, stable, cnt_y, cnt_x}), 32'h0);
        srst = 1'b0;
        intf.z = 1'b0;
        step(); step();
        check("abort_post_rise", 32'(rise), 32'h0);

        intf.z = 1'b1; intf.y = 1'b1; intf.x = 1'b1;
        step(); step();
        check("simul_rise",  32'(rise), 32'h7);
        check("simul_cnt8",  32'({cnt_z, cnt_y, cnt_x}), 32'h010101);
        check("simul_cnt2",  32'({cnt2_z, cnt2_y, cnt2_x}), 32'h15);
        check("simul_rise2", 32'(rise2), 32'h7);
        step();
        check("simul_rise_once", 32'(rise), 32'h0);
        check("simul_cnt_hold",  32'({cnt_z, cnt_y, cnt_x}), 32'h010101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
